// File: rtl/mem_pkg.sv
// Shared types and default widths for the data-memory channel arbiters.
package mem_pkg;

  localparam int ADDR_BITS_DEF     = 8;
  localparam int DATA_BITS_DEF     = 8;
  localparam int NUM_CONSUMERS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELAY
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] winner
);

  // Scan from the farthest offset down so the nearest request is written last.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory channel among several cache ports,
// one transaction in flight at a time.
module mem_rr_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_DEF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);

  arb_state_t               state;
  logic [IDX_W-1:0]         pointer;
  logic [IDX_W-1:0]         grant;
  logic                     grant_is_read;
  logic [NUM_CONSUMERS-1:0] relay_mask;
  logic [NUM_CONSUMERS-1:0] pending;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_winner;

  always_comb begin
    relay_mask = '0;
    if (state == RELAY) relay_mask[grant] = 1'b1;
  end

  assign pending = (consumer_read_valid | consumer_write_valid) & ~relay_mask;

  rr_pick #(
    .N     (NUM_CONSUMERS),
    .PTR_W (IDX_W)
  ) u_pick (
    .req    (pending),
    .ptr    (pointer),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      pointer              <= '0;
      grant                <= '0;
      grant_is_read        <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_winner;
            // A port asserting both read and write gets its read served first.
            if (consumer_read_valid[pick_winner]) begin
              grant_is_read    <= 1'b1;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick_winner];
              state            <= READ_WAIT;
            end else begin
              grant_is_read     <= 1'b0;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick_winner];
              mem_write_data    <= consumer_write_data[pick_winner];
              state             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            consumer_read_ready[grant] <= 1'b1;
            consumer_read_data[grant]  <= mem_read_data;
            state                      <= RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            state                       <= RELAY;
          end
        end
        RELAY: begin
          if (grant_is_read ? !consumer_read_valid[grant] : !consumer_write_valid[grant]) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            pointer              <= (grant == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant + 1'b1;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: consumer agents, a latency-programmable memory
// model answering reads with addr ^ 8'h99, and an in-order completion queue.
module tb_mem_rr_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NC = 4;

  logic                   clk;
  logic                   reset;
  logic [NC-1:0]          consumer_read_valid;
  logic [NC-1:0][AW-1:0]  consumer_read_address;
  logic [NC-1:0]          consumer_read_ready;
  logic [NC-1:0][DW-1:0]  consumer_read_data;
  logic [NC-1:0]          consumer_write_valid;
  logic [NC-1:0][AW-1:0]  consumer_write_address;
  logic [NC-1:0][DW-1:0]  consumer_write_data;
  logic [NC-1:0]          consumer_write_ready;
  logic                   mem_read_valid;
  logic [AW-1:0]          mem_read_address;
  logic                   mem_read_ready;
  logic [DW-1:0]          mem_read_data;
  logic                   mem_write_valid;
  logic [AW-1:0]          mem_write_address;
  logic [DW-1:0]          mem_write_data;
  logic                   mem_write_ready;

  mem_rr_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  typedef struct {
    int         id;
    bit         rd;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  typedef struct {
    int         id;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  req_t stim_q[$];
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mem_lat = 1;
  int mem_fires = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_req(input int id, input bit rd, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata);
    req_t r;
    r.id = id; r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
    stim_q.push_back(r);
  endtask

  task automatic expect_tx(input int id, input bit rd, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.id = id; e.rd = rd; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stim_q.size() == 0 && exp_q.size() == 0 &&
          consumer_read_valid == '0 && consumer_write_valid == '0) break;
    end
    check_eq("drain", stim_q.size() + exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Agents, memory model and completion monitor, all sampled on the falling edge.
  initial begin
    logic [NC-1:0] prev_rd, prev_wr, rd_rise, wr_rise, rd_drop, wr_drop, hold;
    logic [7:0]    seen_addr, seen_wdata;
    bit            busy, busy_rd;
    int            cnt, rdy_cyc;
    prev_rd = '0; prev_wr = '0; rd_drop = '0; wr_drop = '0; hold = '0;
    seen_addr = '0; seen_wdata = '0; busy = 0; busy_rd = 0; cnt = 0; rdy_cyc = 0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_rd = '0; prev_wr = '0; rd_drop = '0; wr_drop = '0; hold = '0;
      end else begin
        for (int i = 0; i < NC; i++) begin
          if (rd_drop[i]) check_eq("rd_ready_drop", consumer_read_ready[i], 0);
          if (wr_drop[i]) check_eq("wr_ready_drop", consumer_write_ready[i], 0);
        end
        rd_rise = consumer_read_ready & ~prev_rd;
        wr_rise = consumer_write_ready & ~prev_wr;
        if ((rd_rise | wr_rise) != '0) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_ready", {consumer_read_ready, consumer_write_ready}, 0);
          end else begin
            exp_t e;
            logic [NC-1:0] onehot;
            e = exp_q.pop_front();
            onehot = NC'(1) << e.id;
            check_eq("rd_ready_vec", consumer_read_ready, e.rd ? onehot : '0);
            check_eq("wr_ready_vec", consumer_write_ready, e.rd ? '0 : onehot);
            check_eq("mem_addr", seen_addr, e.addr);
            check_eq("ready_latency", cyc - rdy_cyc, 1);
            if (e.rd) begin
              check_eq("rd_data", consumer_read_data[e.id], e.data);
              check_eq("mem_rd_valid_low", mem_read_valid, 0);
            end else begin
              check_eq("mem_wr_data", seen_wdata, e.data);
              check_eq("mem_wr_valid_low", mem_write_valid, 0);
            end
          end
        end
        prev_rd = consumer_read_ready;
        prev_wr = consumer_write_ready;
        rd_drop = '0; wr_drop = '0;
        for (int i = 0; i < NC; i++) begin
          bit dropped;
          dropped = 0;
          if (consumer_read_ready[i] && consumer_read_valid[i]) begin
            consumer_read_valid[i] = 1'b0; rd_drop[i] = 1'b1; dropped = 1;
          end
          if (consumer_write_ready[i] && consumer_write_valid[i]) begin
            consumer_write_valid[i] = 1'b0; wr_drop[i] = 1'b1; dropped = 1;
          end
          if (dropped) begin
            hold[i] = 1'b1;
          end else if (hold[i]) begin
            hold[i] = 1'b0;
          end else if (!consumer_read_valid[i] && !consumer_write_valid[i]) begin
            bit got;
            got = 0;
            for (int j = 0; j < stim_q.size() && !got; j++) begin
              if (stim_q[j].id == i) begin
                got = 1;
                consumer_read_valid[i]    = stim_q[j].rd;
                consumer_read_address[i]  = stim_q[j].addr;
                consumer_write_valid[i]   = stim_q[j].wr;
                consumer_write_address[i] = stim_q[j].addr;
                consumer_write_data[i]    = stim_q[j].wdata;
                stim_q.delete(j);
              end
            end
          end
        end
      end
      if (mem_read_ready || mem_write_ready) begin
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; busy = 0;
      end else if (busy) begin
        if (busy_rd && mem_read_valid) check_eq("mem_rd_addr_hold", mem_read_address, seen_addr);
        if (cnt == 0) begin
          rdy_cyc = cyc; mem_fires++;
          if (busy_rd) begin
            mem_read_ready = 1'b1; mem_read_data = seen_addr ^ 8'h99;
          end else begin
            mem_write_ready = 1'b1;
          end
        end else begin
          cnt--;
        end
      end else if (mem_read_valid) begin
        busy = 1; busy_rd = 1; seen_addr = mem_read_address; cnt = mem_lat - 1;
      end else if (mem_write_valid) begin
        busy = 1; busy_rd = 0; seen_addr = mem_write_address; seen_wdata = mem_write_data;
        cnt = mem_lat - 1;
      end
    end
  end

  initial begin
    int fires_before;
    reset = 1'b1;
    consumer_read_valid = '0; consumer_read_address = '0;
    consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_mem_valids", {mem_read_valid, mem_write_valid}, 0);
    check_eq("rst_mem_addrs", {mem_read_address, mem_write_address, mem_write_data}, 0);
    check_eq("rst_readies", {consumer_read_ready, consumer_write_ready}, 0);
    check_eq("rst_rd_data", consumer_read_data, 0);
    #2 reset = 1'b0;

    // Fairness from pointer 0: two rounds of continuous reads.
    @(negedge clk); #1;
    mem_lat = 1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NC; i++) begin
        logic [7:0] a;
        a = 8'(8'h40 + i * 16 + k);
        add_req(i, 1, 0, a, 8'h00);
        expect_tx(i, 1, a, a ^ 8'h99);
      end
    wait_drain(300);

    // Single read, 3-cycle memory; pointer ends at 3.
    mem_lat = 3;
    add_req(2, 1, 0, 8'h3C, 8'h00);
    expect_tx(2, 1, 8'h3C, 8'hA5);
    wait_drain(100);

    // Pointer 3: consumer 3 beats 2.
    mem_lat = 1;
    add_req(2, 1, 0, 8'h22, 8'h00); add_req(3, 1, 0, 8'h33, 8'h00);
    expect_tx(3, 1, 8'h33, 8'h33 ^ 8'h99); expect_tx(2, 1, 8'h22, 8'h22 ^ 8'h99);
    wait_drain(100);

    // Wrap-around from pointer 3: consumer 0 before 2.
    add_req(2, 1, 0, 8'h2A, 8'h00); add_req(0, 1, 0, 8'h0A, 8'h00);
    expect_tx(0, 1, 8'h0A, 8'h0A ^ 8'h99); expect_tx(2, 1, 8'h2A, 8'h2A ^ 8'h99);
    wait_drain(100);

    // Single write; pointer ends at 1.
    mem_lat = 2;
    add_req(0, 0, 1, 8'h10, 8'h77);
    expect_tx(0, 0, 8'h10, 8'h77);
    wait_drain(100);

    // Read+write on consumer 1: read first, write after the rotation reaches it again.
    mem_lat = 1;
    add_req(1, 1, 1, 8'h5B, 8'hC3); add_req(2, 1, 0, 8'h6B, 8'h00); add_req(0, 1, 0, 8'h7B, 8'h00);
    expect_tx(1, 1, 8'h5B, 8'h5B ^ 8'h99);
    expect_tx(2, 1, 8'h6B, 8'h6B ^ 8'h99);
    expect_tx(0, 1, 8'h7B, 8'h7B ^ 8'h99);
    expect_tx(1, 0, 8'h5B, 8'hC3);
    wait_drain(150);

    // Reset in READ_WAIT, late memory ready after release.
    mem_lat = 8;
    add_req(1, 1, 0, 8'h5A, 8'h00);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_read_valid) break;
    end
    check_eq("pre_rst_rd_valid", mem_read_valid, 1);
    fires_before = mem_fires;
    #2 reset = 1'b1;
    consumer_read_valid[1] = 1'b0;
    #1;
    check_eq("async_rst_valids", {mem_read_valid, mem_write_valid}, 0);
    check_eq("async_rst_addr", mem_read_address, 0);
    check_eq("async_rst_readies", {consumer_read_ready, consumer_write_ready}, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("late_mem_ready_seen", mem_fires - fires_before, 1);
    check_eq("late_ready_ignored", {consumer_read_ready, consumer_write_ready, mem_read_valid}, 0);
    #1;

    // Pointer back at 0: consumer 0 before 3.
    mem_lat = 1;
    add_req(3, 1, 0, 8'h3E, 8'h00); add_req(0, 1, 0, 8'h0E, 8'h00);
    expect_tx(0, 1, 8'h0E, 8'h0E ^ 8'h99); expect_tx(3, 1, 8'h3E, 8'h3E ^ 8'h99);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
